// File: rtl/lime_test_sequencer.sv
// Vector-driven test harness for TheLime-class cores: applies stored input/expected pairs,
// pulses the core reset per vector and scores match/timeout. Macro LIME_SEQ_CYCLE_LOG_EN adds a cycles-to-match log.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// APPLY | vector input driven, core reset held RST_CYCLES cycles
// WAIT  | core running, output compared against expected until match or timeout
// NEXT  | one-cycle gap with core in reset, advance index or finish
// DONE  | results held until the next start
module lime_test_sequencer #(
  parameter int WIDTH          = 16,
  parameter int NUM_VECTORS    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int RST_CYCLES     = 2,
  localparam int AW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
  localparam int CW = $clog2(NUM_VECTORS + 1),
  localparam int LW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   vec_we_i,
  input  logic [AW-1:0]          vec_addr_i,
  input  logic [WIDTH-1:0]       vec_in_i,
  input  logic [WIDTH-1:0]       vec_exp_i,
  input  logic                   start_i,
  input  logic [WIDTH-1:0]       dut_output_i,
  output logic [WIDTH-1:0]       dut_input_o,
  output logic                   dut_rst_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   all_pass_o,
  output logic [CW-1:0]          pass_count_o,
  output logic [CW-1:0]          fail_count_o,
  output logic [NUM_VECTORS-1:0] fail_mask_o,
  input  logic [AW-1:0]          log_addr_i,
  output logic [LW-1:0]          cycle_log_o
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [AW-1:0]          idx_q;
  logic [RW-1:0]          rst_cnt_q;
  logic [LW-1:0]          wait_cnt_q;
  logic [WIDTH-1:0]       dut_input_q;
  logic                   dut_rst_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   all_pass_q;
  logic [CW-1:0]          pass_count_q;
  logic [CW-1:0]          fail_count_q;
  logic [NUM_VECTORS-1:0] fail_mask_q;

  logic [WIDTH-1:0] vec_in_q  [NUM_VECTORS];
  logic [WIDTH-1:0] vec_exp_q [NUM_VECTORS];

  logic vec_addr_ok;
  logic match;

  assign vec_addr_ok = (32'(vec_addr_i) < NUM_VECTORS);
  assign match       = (dut_output_i == vec_exp_q[idx_q]);

  // Table survives reset so a run can be repeated after an abort without reloading.
  always_ff @(posedge clk_i) begin
    if (vec_we_i && !busy_q && vec_addr_ok) begin
      vec_in_q[vec_addr_i]  <= vec_in_i;
      vec_exp_q[vec_addr_i] <= vec_exp_i;
    end
  end

`ifdef LIME_SEQ_CYCLE_LOG_EN
  logic [LW-1:0] log_q [NUM_VECTORS];
  assign cycle_log_o = (32'(log_addr_i) < NUM_VECTORS) ? log_q[log_addr_i] : '0;
`else
  logic unused_log_addr;
  assign unused_log_addr = ^log_addr_i;
  assign cycle_log_o     = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      rst_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      dut_input_q  <= '0;
      dut_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      all_pass_q   <= 1'b0;
      pass_count_q <= '0;
      fail_count_q <= '0;
      fail_mask_q  <= '0;
`ifdef LIME_SEQ_CYCLE_LOG_EN
      for (int i = 0; i < NUM_VECTORS; i++) log_q[i] <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            pass_count_q <= '0;
            fail_count_q <= '0;
            fail_mask_q  <= '0;
            done_q       <= 1'b0;
            all_pass_q   <= 1'b0;
            busy_q       <= 1'b1;
            idx_q        <= '0;
            dut_input_q  <= vec_in_q[0];
            rst_cnt_q    <= RW'(RST_CYCLES - 1);
            state_q      <= S_APPLY;
`ifdef LIME_SEQ_CYCLE_LOG_EN
            for (int i = 0; i < NUM_VECTORS; i++) log_q[i] <= '0;
`endif
          end
        end
        S_APPLY: begin
          if (rst_cnt_q == '0) begin
            dut_rst_q  <= 1'b0;
            wait_cnt_q <= LW'(1);
            state_q    <= S_WAIT;
          end else begin
            rst_cnt_q <= rst_cnt_q - RW'(1);
          end
        end
        S_WAIT: begin
          // A match on the final allowed cycle still counts as a pass.
          if (match) begin
            pass_count_q <= pass_count_q + CW'(1);
            dut_rst_q    <= 1'b1;
            state_q      <= S_NEXT;
`ifdef LIME_SEQ_CYCLE_LOG_EN
            log_q[idx_q] <= wait_cnt_q;
`endif
          end else if (wait_cnt_q == LW'(TIMEOUT_CYCLES)) begin
            fail_count_q       <= fail_count_q + CW'(1);
            fail_mask_q[idx_q] <= 1'b1;
            dut_rst_q          <= 1'b1;
            state_q            <= S_NEXT;
`ifdef LIME_SEQ_CYCLE_LOG_EN
            log_q[idx_q] <= '0;
`endif
          end else begin
            wait_cnt_q <= wait_cnt_q + LW'(1);
          end
        end
        S_NEXT: begin
          if (idx_q == LAST_IDX) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            all_pass_q <= (fail_count_q == '0);
            state_q    <= S_DONE;
          end else begin
            idx_q       <= idx_q + AW'(1);
            dut_input_q <= vec_in_q[idx_q + AW'(1)];
            rst_cnt_q   <= RW'(RST_CYCLES - 1);
            state_q     <= S_APPLY;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dut_input_o  = dut_input_q;
  assign dut_rst_o    = dut_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign all_pass_o   = all_pass_q;
  assign pass_count_o = pass_count_q;
  assign fail_count_o = fail_count_q;
  assign fail_mask_o  = fail_mask_q;

endmodule
